// File: rtl/my_pkg.sv
// Shared fetch-path constants and the decode-facing entry type.
// pc_reg takes its reset value from RESET_PC here.
package my_pkg;

   localparam int ADDR_WIDTH  = 32;
   localparam int DATA_WIDTH  = 32;
   localparam int INSTR_BYTES = 4;
   localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_1000;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush, registered storage and a head-of-queue read port.
// A push when full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | do_pop);
   assign head_data = mem[rd_ptr];

   // Flush wins over a same-cycle push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch control: credit-limited in-order imem requests, PC queue for
// in-flight fetches, instruction buffer for decode, and pc_next back to pc_reg.
module ifetch_ctrl
   import my_pkg::*;
#(
   parameter int ADDR_WIDTH = my_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = my_pkg::DATA_WIDTH,
   parameter int FIFO_DEPTH = 2,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = my_pkg::RESET_PC
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] pc_current,
   output logic [ADDR_WIDTH-1:0] pc_next,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   output logic                  if_valid,
   input  logic                  if_ready,
   output logic [ADDR_WIDTH-1:0] if_pc,
   output logic [DATA_WIDTH-1:0] if_instr
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   // Handshakes: a transfer happens on a cycle where valid & ready are both high;
   // a raised valid holds its payload until accepted (a redirect may withdraw a
   // request). The response channel has no ready: credit guarantees it a slot.

   logic [CNT_W-1:0]      outstanding;
   logic [CNT_W-1:0]      fifo_count;
   logic [CNT_W-1:0]      drop_cnt;
   logic                  credit_ok;
   logic                  req_fire;
   logic                  rsp_drop;
   logic                  rsp_keep;
   logic                  if_pop;
   logic [ADDR_WIDTH-1:0] rsp_pc;
   logic                  pcq_full;
   logic                  pcq_empty;
   logic                  ififo_full;
   logic                  ififo_empty;
   fetch_entry_t          rsp_entry;
   fetch_entry_t          head_entry;

   assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);

   assign imem_req_valid = rst_n & credit_ok & ~redirect_valid;
   assign imem_req_addr  = pc_current;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // Responses are discarded while older-path fetches drain, and always on a redirect cycle.
   assign rsp_drop  = imem_rsp_valid & (redirect_valid | (drop_cnt != '0));
   assign rsp_keep  = imem_rsp_valid & ~rsp_drop;
   assign rsp_entry = '{pc: rsp_pc, instr: imem_rsp_data};

   assign if_valid = ~ififo_empty;
   assign if_pc    = head_entry.pc;
   assign if_instr = head_entry.instr;
   assign if_pop   = if_valid & if_ready & ~redirect_valid;

   // Occupancy of the PC queue is exactly the number of outstanding requests.
   sync_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_pc_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (1'b0),
      .push      (req_fire),
      .push_data (pc_current),
      .pop       (imem_rsp_valid),
      .head_data (rsp_pc),
      .count     (outstanding),
      .full      (pcq_full),
      .empty     (pcq_empty)
   );

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_instr_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (rsp_keep),
      .push_data (rsp_entry),
      .pop       (if_pop),
      .head_data (head_entry),
      .count     (fifo_count),
      .full      (ififo_full),
      .empty     (ififo_empty)
   );

   // outstanding already counts fetches still to be dropped, so it replaces drop_cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
      end else if (imem_rsp_valid && (drop_cnt != '0)) begin
         drop_cnt <= drop_cnt - CNT_W'(1);
      end
   end

   always_comb begin
      pc_next = pc_current;
      if (rst_n) begin
         if (redirect_valid) begin
            pc_next = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         end else if (req_fire) begin
            pc_next = pc_current + ADDR_WIDTH'(INSTR_BYTES);
         end
      end
   end

   a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> !pcq_empty);
   a_pcq_room: assert property (@(posedge clk) disable iff (!rst_n)
      req_fire |-> !pcq_full);
   a_fifo_room: assert property (@(posedge clk) disable iff (!rst_n)
      rsp_keep |-> (!ififo_full || if_pop));
   a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (imem_req_valid && !imem_req_ready) |=> (imem_req_valid || redirect_valid));
   a_reset_pc: assert property (@(posedge clk)
      $rose(rst_n) |-> (pc_current == RESET_PC));

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch control stage directly downstream of pc_reg. It consumes pc_current, issues in-order requests to instruction memory over a valid/ready handshake, and buffers returned instructions with their PCs in a small FIFO for decode. It computes pc_next, which closes the loop back into pc_reg. Holding the PC is done by driving pc_next = pc_current, because pc_reg has no enable.

Parameters:
ADDR_WIDTH, 32, address/PC width (value from my_pkg)
DATA_WIDTH, 32, instruction width
FIFO_DEPTH, 2, instruction buffer entries; also the max in-flight-plus-buffered credit
RESET_PC, 32'h0000_1000, reset PC (my_pkg constant, shared with pc_reg)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pc_current  in  ADDR_WIDTH  PC from pc_reg
pc_next  out  ADDR_WIDTH  next PC to pc_reg
redirect_valid  in  1  branch/jump/trap redirect from execute
redirect_pc  in  ADDR_WIDTH  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_WIDTH  fetch address
imem_rsp_valid  in  1  response valid; in-order; no backpressure
imem_rsp_data  in  DATA_WIDTH  instruction word
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts
if_pc  out  ADDR_WIDTH  PC of head instruction
if_instr  out  DATA_WIDTH  head instruction

Behaviour:
- Reset:
  - Asynchronous reset is rst_n, active-low; clock is clk.
  - During reset, all counters, the FIFO, the PC queue and drop_cnt are cleared.
  - imem_req_valid=0 and if_valid=0 during reset.
  - pc_next = pc_current (combinational), so pc_reg holds RESET_PC.
- Credit: outstanding (0..FIFO_DEPTH) + fifo_count must be < FIFO_DEPTH to issue. This guarantees every response has a FIFO slot, so the response side has no ready.
- Request: imem_req_valid = credit_ok & !redirect_valid; imem_req_addr = pc_current.
  - Handshake (valid & ready): outstanding++ and pc_current is pushed into a PC queue of depth FIFO_DEPTH.
  - imem_req_valid, once high, stays high with a stable address until ready, unless a redirect arrives.
- pc_next priority:
  - redirect_valid: pc_next = {redirect_pc[ADDR_WIDTH-1:2],2'b00}.
  - Otherwise, request handshake: pc_next = pc_current+4, wrapping modulo 2^ADDR_WIDTH.
  - Otherwise: pc_next = pc_current.
- Response:
  - Each imem_rsp_valid pulse decrements outstanding and pops the PC queue.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {popped pc, imem_rsp_data} is pushed into the instruction FIFO.
  - Response latency is unconstrained (≥1 cycle after request handshake).
- Output: if_valid = fifo_count!=0; if_pc/if_instr are the FIFO head. Pop on if_valid & if_ready. Push and pop in the same cycle leaves the count unchanged and is legal when full.
- Minimum latency: request handshake in cycle N, response in cycle N+1, if_valid in N+2 (registered FIFO).
- Redirect (single cycle):
  - The instruction FIFO is flushed and any same-cycle pop is ignored.
  - No request is issued that cycle.
  - drop_cnt <= outstanding minus the same-cycle response (if any). A same-cycle response is always dropped.
  - Existing drop_cnt is not added, since it is already included in outstanding.
  - New-path requests may issue from the next cycle while older responses drain.
- Back-to-back redirects: each recomputes drop_cnt from outstanding; the last target wins.
- Responses arriving with outstanding==0 are illegal and are asserted against in simulation.
- Reset mid-operation: all in-flight state is discarded. Memory must also be reset by the same rst_n.

Decomposition:
- my_pkg holds ADDR_WIDTH, DATA_WIDTH, RESET_PC, INSTR_BYTES=4, and a typedef fetch_entry_t {pc, instr}.
- One sub-module, sync_fifo: parameterised width/depth with flush, push, pop, count, full and empty. It is instantiated twice: for the PC queue (ADDR_WIDTH) and the instruction FIFO (fetch_entry_t).

Test Plan:
1. Reset then stream: rst_n low, pc_current=0x1000, imem_req_ready=1, rsp 1 cycle later, if_ready=1 → requests 0x1000, 0x1004, 0x1008…; if_pc=0x1000 with if_instr=rsp word, in order; pc_next increments by 4 per handshake.
2. Memory stall: imem_req_ready=0 for 5 cycles → imem_req_valid held, addr stable at 0x1004, pc_next=pc_current=0x1004.
3. Decode backpressure: if_ready=0 → after 2 entries buffered, imem_req_valid drops; outstanding+count never exceeds 2; no response is lost when if_ready rises.
4. Redirect with 2 outstanding: redirect_pc=0x2003 → pc_next=0x2000, FIFO empty next cycle, next two responses dropped, first if_pc=0x2000.
5. Redirect coincident with response and pop: response dropped, drop_cnt=outstanding-1, no if_valid from old path.
6. Wrap: pc_current=0xFFFF_FFFC, handshake → pc_next=0x0000_0000; async reset asserted mid-burst → if_valid=0 and imem_req_valid=0 immediately.
